// File: rtl/dds_wave_gen.sv
// Single-channel DDS waveform generator: sine (external LUT), square, triangle and
// frequency sweep, scaled by amplitude and gain correction onto an unsigned DAC code.
module dds_wave_gen #(
    parameter int DAC_W     = 10,
    parameter int PHASE_W   = 32,
    parameter int LUT_AW    = 10,
    parameter int GAIN_W    = 11,
    parameter int GAIN_FRAC = 10,
    parameter int FTW_STEP  = 10486,
    parameter int FREQ_MIN  = 1,
    parameter int FREQ_MAX  = 30,
    parameter int AMP_MIN   = 10,
    parameter int AMP_MAX   = 20,
    parameter int SWEEP_CYC = 4096000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freq_up,
    input  logic              freq_dn,
    input  logic              amp_up,
    input  logic              amp_dn,
    input  logic [1:0]        mode,
    input  logic [GAIN_W-1:0] gain,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [DAC_W-1:0]  lut_data,
    output logic [4:0]        freq_idx,
    output logic [4:0]        amp_idx,
    output logic [DAC_W-1:0]  da_data,
    output logic              da_valid
);
    localparam int S_W  = DAC_W + 1;
    localparam int P_W  = S_W + 6 + GAIN_W + 1;
    localparam int SW_W = (SWEEP_CYC > 1) ? $clog2(SWEEP_CYC) : 1;

    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SWEEP  = 2'd3;

    localparam logic [4:0] F_MIN = 5'(FREQ_MIN);
    localparam logic [4:0] F_MAX = 5'(FREQ_MAX);
    localparam logic [4:0] A_MIN = 5'(AMP_MIN);
    localparam logic [4:0] A_MAX = 5'(AMP_MAX);

    localparam logic [SW_W-1:0]        SWEEP_LAST = SW_W'(SWEEP_CYC - 1);
    localparam logic signed [S_W-1:0]  HALF_S     = S_W'(2**(DAC_W-1) - 1);
    localparam logic signed [P_W-1:0]  AMP_DIV    = P_W'(AMP_MAX);
    localparam logic signed [P_W-1:0]  MID_P      = P_W'(2**(DAC_W-1));
    localparam logic signed [P_W-1:0]  TOP_P      = P_W'(2**DAC_W - 1);
    localparam logic [DAC_W-1:0]       MID_CODE   = DAC_W'(2**(DAC_W-1));

    logic [SW_W-1:0]        sweep_cnt;
    logic [4:0]             freq_wrap_up;
    logic [4:0]             freq_wrap_dn;
    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W-1:0]     ftw;
    logic [DAC_W-1:0]       ph_top_d;
    logic signed [S_W-1:0]  tri_x2;
    logic signed [S_W-1:0]  s_sel;
    logic signed [S_W-1:0]  s_reg;
    logic signed [P_W-1:0]  p_nxt;
    logic signed [P_W-1:0]  p_reg;
    logic signed [P_W-1:0]  q;
    logic signed [P_W-1:0]  r;
    logic signed [P_W-1:0]  code_full;
    logic [DAC_W-1:0]       code_nxt;
    logic [1:0]             vld_sr;

    assign freq_wrap_up = (freq_idx == F_MAX) ? F_MIN : freq_idx + 5'd1;
    assign freq_wrap_dn = (freq_idx == F_MIN) ? F_MAX : freq_idx - 5'd1;

    // Sweep mode owns freq_idx; keys only steer it outside sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_idx  <= F_MIN;
            sweep_cnt <= '0;
        end else if (mode == MODE_SWEEP) begin
            if (sweep_cnt == SWEEP_LAST) begin
                sweep_cnt <= '0;
                freq_idx  <= freq_wrap_up;
            end else begin
                sweep_cnt <= sweep_cnt + SW_W'(1);
            end
        end else begin
            sweep_cnt <= '0;
            if (freq_up && !freq_dn) begin
                freq_idx <= freq_wrap_up;
            end else if (freq_dn && !freq_up) begin
                freq_idx <= freq_wrap_dn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_idx <= A_MIN;
        end else if (amp_up && !amp_dn && amp_idx < A_MAX) begin
            amp_idx <= amp_idx + 5'd1;
        end else if (amp_dn && !amp_up && amp_idx > A_MIN) begin
            amp_idx <= amp_idx - 5'd1;
        end
    end

    // ph_top_d travels with lut_addr so square/triangle line up with the LUT sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ftw      <= '0;
            phase    <= '0;
            lut_addr <= '0;
            ph_top_d <= '0;
        end else begin
            ftw      <= PHASE_W'(freq_idx) * PHASE_W'(FTW_STEP);
            phase    <= phase + ftw;
            lut_addr <= phase[PHASE_W-1 -: LUT_AW];
            ph_top_d <= phase[PHASE_W-1 -: DAC_W];
        end
    end

    always_comb begin
        tri_x2 = {1'b0, ph_top_d[DAC_W-2:0], 1'b0};
        s_sel  = $signed({lut_data[DAC_W-1], lut_data});
        case (mode)
            MODE_SQUARE: s_sel = ph_top_d[DAC_W-1] ? -HALF_S : HALF_S;
            MODE_TRI:    s_sel = ph_top_d[DAC_W-1] ? HALF_S - tri_x2 : tri_x2 - HALF_S;
            default:     ;
        endcase
    end

    assign p_nxt = P_W'(s_reg) * P_W'($signed({1'b0, amp_idx})) * P_W'($signed({1'b0, gain}));

    always_comb begin
        q         = p_reg >>> GAIN_FRAC;
        r         = q / AMP_DIV;
        code_full = r + MID_P;
        if (code_full[P_W-1]) begin
            code_nxt = '0;
        end else if (code_full > TOP_P) begin
            code_nxt = '1;
        end else begin
            code_nxt = code_full[DAC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_reg    <= '0;
            p_reg    <= '0;
            da_data  <= MID_CODE;
            vld_sr   <= '0;
            da_valid <= 1'b0;
        end else begin
            s_reg    <= s_sel;
            p_reg    <= p_nxt;
            da_data  <= code_nxt;
            vld_sr   <= {vld_sr[0], 1'b1};
            da_valid <= vld_sr[1];
        end
    end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Parametrised single-channel direct-digital-synthesis waveform generator. It drives the DAC data bus in place of the fixed sine-only path. It holds the frequency index and amplitude index under key-pulse control and generates sine (from an external sine LUT), square or triangle waves, plus an automatic frequency-sweep mode. Each sample is scaled by amplitude and by a per-frequency gain-correction word, offset to unsigned DAC code, and clamped. The block sits in the DAC clock domain between the debounced key pulses, the gain ROM and the DAC pins.

## Interface
Parameters:
- DAC_W, 10: DAC code width; LUT sample width is also DAC_W (signed).
- PHASE_W, 32: phase accumulator width.
- LUT_AW, 10: sine LUT address width (full cycle).
- GAIN_W, 11: gain-correction width, unsigned, GAIN_FRAC fractional bits.
- GAIN_FRAC, 10: gain fractional bits (1024 = unity).
- FTW_STEP, 10486: tuning-word increment per frequency index (100 Hz at 40.96 MHz).
- FREQ_MIN, 1 and FREQ_MAX, 30: frequency index range.
- AMP_MIN, 10 and AMP_MAX, 20: amplitude index range (tenths of a volt). AMP_MAX is also the amplitude divisor.
- SWEEP_CYC, 4096000: clocks per sweep step.

Ports:
- clk  in  1  DAC-domain clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- freq_up, freq_dn, amp_up, amp_dn  in  1 each  single-cycle pulses, already synchronous to clk.
- mode  in  2  0 = sine, 1 = square, 2 = triangle, 3 = sine with sweep.
- gain  in  GAIN_W  gain correction for the current freq_idx; sampled every cycle.
- lut_addr  out  LUT_AW  sine LUT address, registered.
- lut_data  in  DAC_W  signed sine sample, valid the cycle after lut_addr.
- freq_idx  out  5  current frequency index.
- amp_idx  out  5  current amplitude index.
- da_data  out  DAC_W  unsigned DAC code.
- da_valid  out  1  high once the pipeline is filled.

## Operation
Reset values:
- freq_idx = FREQ_MIN, amp_idx = AMP_MIN.
- Phase accumulator = 0, FTW register = 0, lut_addr = 0.
- da_data = 2^(DAC_W-1) (512), da_valid = 0.
- Sweep counter = 0.

Frequency index control (mode != 3):
- freq_up increments freq_idx, wrapping FREQ_MAX→FREQ_MIN.
- freq_dn decrements freq_idx, wrapping FREQ_MIN→FREQ_MAX.
- freq_up and freq_dn in the same cycle: no change.

Amplitude index control:
- amp_up and amp_dn saturate at AMP_MAX and AMP_MIN.
- Both in the same cycle: no change.
- Active in all modes.

Sweep (mode = 3):
- The sweep counter counts 0..SWEEP_CYC-1.
- On the terminal count, freq_idx advances by 1, wrapping FREQ_MAX→FREQ_MIN.
- freq_up and freq_dn are ignored.
- Leaving mode 3 clears the counter; freq_idx keeps its current value.

Phase and tuning word:
- FTW is registered as freq_idx × FTW_STEP.
- The phase accumulator adds FTW every cycle, modulo 2^PHASE_W.
- Frequency and mode changes never reset the phase; phase stays continuous.
- lut_addr = phase[PHASE_W-1 -: LUT_AW].

Sample selection:
- Sample s (signed, DAC_W+1 bits) is chosen per mode from a phase copy delayed to align with lut_data.
- Sine: s = lut_data.
- Square: s = +(2^(DAC_W-1)-1) when phase MSB = 0, otherwise -(2^(DAC_W-1)-1), i.e. ±511.
- Triangle: u = phase[PHASE_W-2 -: DAC_W-1]. s = 2u - 511 when MSB = 0, otherwise 511 - 2u.

Scaling:
- p = s × amp_idx × gain, signed, full width with no overflow.
- q = p >>> GAIN_FRAC (arithmetic shift).
- r = q / AMP_MAX, truncated toward zero.
- code = r + 2^(DAC_W-1), clamped to [0, 2^DAC_W-1].

## Timing
Pipeline, with lut_addr registered at edge t:
- t+1: lut_data is sampled and s is selected.
- t+2: product is registered.
- t+3: da_data is registered.
- Latency lut_addr→da_data is 3 cycles for all modes; square and triangle use the same delayed phase.

Control latencies:
- Key pulse at edge k: freq_idx or amp_idx updates at k+1.
- FTW uses the new freq_idx at k+2.
- amp_idx and gain are used at the multiply stage in whatever cycle they are present; there is no sample-to-gain alignment.

Reset behaviour:
- da_valid rises 3 cycles after the first cycle with rst_n = 1.
- Reset asserted mid-operation returns every register to its reset value at the next edge.

## Test plan
- Reset: rst_n low 2 cycles, then high → da_data = 512, freq_idx = 1, amp_idx = 10, da_valid = 1 on the 3rd cycle after release.
- Frequency wrap and collision: 3× freq_up → freq_idx = 4. Reset, then freq_dn → 30. freq_up with freq_dn together → unchanged.
- Amplitude saturation: 15× amp_up → amp_idx = 20. 15× amp_dn → 10.
- Square scaling, gain = 512, amp_idx = 10: da_data = 639 while phase MSB = 0, 385 otherwise. With gain = 1024, amp_idx = 20: da_data = 1023 and 1.
- Latency and clamp in sine mode, with the bench returning lut_data = 511 one cycle after any address:
  - Gain 2047, amp_idx 20 → da_data = 1023 exactly 3 cycles after lut_addr.
  - lut_data = -511 → da_data = 0.
- Sweep with SWEEP_CYC = 8, mode = 3, freq_idx = 29:
  - freq_idx reads 30 after 8 cycles, then 1 after 16.
  - freq_up is ignored.
  - After a return to mode 0, freq_idx holds its value.
